// File: rtl/msrv32_alu_arbiter.sv
// msrv32_alu_arbiter
//   Shares one msrv32_alu between two requesters through a two-stage pipeline.
//   Requester 0 is the integer execute path. Requester 1 is the auxiliary
//   address/compare path.
//   S1 (issue) holds the winning request and drives the ALU directly.
//   S2 (output) captures the ALU result with its tag and source, and supports
//   consumer backpressure.
//
// Ports
//   clk_in, rst_n_in             clock, asynchronous active-low reset
//   flush_in                     synchronous discard of S1/S2 contents
//   reqN_valid_in/ready_out      request handshake, N = 0,1
//   reqN_op_1_in/op_2_in         32-bit operands
//   reqN_opcode_in               4-bit ALU opcode (not decoded here)
//   reqN_tag_in                  TAG_W-bit tag returned with the result
//   alu_op_1/op_2/opcode_out     ALU drive, taken from the issue register
//   alu_result_in                combinational ALU result
//   res_valid_out/res_ready_in   result handshake
//   res_data_out/tag_out/src_out result payload
//
// Optional feature: define MSRV32_ALU_ARB_STATS_EN to add saturating 16-bit
//   counters stat_grant0_out, stat_grant1_out and stat_stall_out.

module msrv32_alu_arbiter #(
   parameter int TAG_W = 3
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             flush_in,
   input  logic             req0_valid_in,
   output logic             req0_ready_out,
   input  logic [31:0]      req0_op_1_in,
   input  logic [31:0]      req0_op_2_in,
   input  logic [3:0]       req0_opcode_in,
   input  logic [TAG_W-1:0] req0_tag_in,
   input  logic             req1_valid_in,
   output logic             req1_ready_out,
   input  logic [31:0]      req1_op_1_in,
   input  logic [31:0]      req1_op_2_in,
   input  logic [3:0]       req1_opcode_in,
   input  logic [TAG_W-1:0] req1_tag_in,
   output logic [31:0]      alu_op_1_out,
   output logic [31:0]      alu_op_2_out,
   output logic [3:0]       alu_opcode_out,
   input  logic [31:0]      alu_result_in,
   output logic             res_valid_out,
   input  logic             res_ready_in,
   output logic [31:0]      res_data_out,
   output logic [TAG_W-1:0] res_tag_out,
   output logic             res_src_out
`ifdef MSRV32_ALU_ARB_STATS_EN
   ,
   output logic [15:0]      stat_grant0_out,
   output logic [15:0]      stat_grant1_out,
   output logic [15:0]      stat_stall_out
`endif
);

   typedef struct packed {
      logic [31:0]      op1;
      logic [31:0]      op2;
      logic [3:0]       opcode;
      logic [TAG_W-1:0] tag;
      logic             src;
   } iss_t;

   typedef struct packed {
      logic [31:0]      data;
      logic [TAG_W-1:0] tag;
      logic             src;
   } res_t;

   logic s1_valid, s2_valid;
   iss_t s1_q, req_sel;
   res_t s2_q;
   logic last_grant;

   logic s2_free, s1_free;
   logic sel0, sel1, accept;

   assign s2_free = !s2_valid | res_ready_in;
   assign s1_free = !s1_valid | s2_free;

   // Round-robin: with both requesters valid, the one that did not win last
   // gets the grant. This is purely combinational on the current valids.
   assign sel0 = req0_valid_in & (!req1_valid_in |  last_grant);
   assign sel1 = req1_valid_in & (!req0_valid_in | !last_grant);

   // Reset gating holds both readies low while reset is asserted, even if a
   // requester is already presenting a request.
   assign req0_ready_out = sel0 & s1_free & !flush_in & rst_n_in;
   assign req1_ready_out = sel1 & s1_free & !flush_in & rst_n_in;
   assign accept         = req0_ready_out | req1_ready_out;

   always_comb begin
      req_sel = '{op1: req0_op_1_in, op2: req0_op_2_in, opcode: req0_opcode_in,
                  tag: req0_tag_in, src: 1'b0};
      if (sel1)
         req_sel = '{op1: req1_op_1_in, op2: req1_op_2_in, opcode: req1_opcode_in,
                     tag: req1_tag_in, src: 1'b1};
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         s1_valid   <= 1'b0;
         s2_valid   <= 1'b0;
         s1_q       <= '0;
         s2_q       <= '0;
         last_grant <= 1'b1;
      end else begin
         if (flush_in) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
         end else begin
            if (s2_free) begin
               s2_valid <= s1_valid;
               if (s1_valid)
                  s2_q <= '{data: alu_result_in, tag: s1_q.tag, src: s1_q.src};
            end
            // S1 drains into S2 whenever it is free, so its valid simply
            // becomes whether a new request is accepted this cycle.
            if (s1_free)
               s1_valid <= accept;
         end
         // accept already excludes the flush cycle
         if (accept) begin
            s1_q       <= req_sel;
            last_grant <= req_sel.src;
         end
      end
   end

   assign alu_op_1_out   = s1_q.op1;
   assign alu_op_2_out   = s1_q.op2;
   assign alu_opcode_out = s1_q.opcode;

   assign res_valid_out  = s2_valid;
   assign res_data_out   = s2_q.data;
   assign res_tag_out    = s2_q.tag;
   assign res_src_out    = s2_q.src;

`ifdef MSRV32_ALU_ARB_STATS_EN
   // Saturating event counters; flush does not touch them.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         stat_grant0_out <= '0;
         stat_grant1_out <= '0;
         stat_stall_out  <= '0;
      end else begin
         if (req0_ready_out & req0_valid_in & (stat_grant0_out != 16'hFFFF))
            stat_grant0_out <= stat_grant0_out + 16'd1;
         if (req1_ready_out & req1_valid_in & (stat_grant1_out != 16'hFFFF))
            stat_grant1_out <= stat_grant1_out + 16'd1;
         if (s2_valid & !res_ready_in & (stat_stall_out != 16'hFFFF))
            stat_stall_out <= stat_stall_out + 16'd1;
      end
   end
`endif

endmodule

// File: doc/msrv32_alu_arbiter.md
# msrv32_alu_arbiter

Two-stage pipelined arbiter that shares one msrv32_alu instance between two requesters. Requester 0 is the integer execute path; requester 1 is the auxiliary address/compare path. The block registers each winning request into an issue stage and drives the ALU from that stage. It captures the ALU result, tagged with source and tag, into an output stage that supports backpressure.

## Interface
- TAG_W, 3: width of the per-request tag returned with each result.
- clk_in  input  1: clock; all state updates on the rising edge.
- rst_n_in  input  1: asynchronous active-low reset.
- flush_in  input  1: synchronous flush; discards issue- and output-stage contents.
- req0_valid_in / req1_valid_in  input  1: request valid, per requester.
- req0_ready_out / req1_ready_out  output  1: request accepted this cycle when valid & ready.
- req0_op_1_in, req0_op_2_in / req1_op_1_in, req1_op_2_in  input  32: operands.
- req0_opcode_in / req1_opcode_in  input  4: ALU opcode, passed through unmodified.
- req0_tag_in / req1_tag_in  input  TAG_W: request tag.
- alu_op_1_out, alu_op_2_out  output  32: operands to msrv32_alu, from the issue register.
- alu_opcode_out  output  4: opcode to msrv32_alu, from the issue register.
- alu_result_in  input  32: msrv32_alu result_out, combinational from the above.
- res_valid_out  output  1: output stage holds a result.
- res_ready_in  input  1: consumer accepts the result when valid & ready.
- res_data_out  output  32: captured ALU result.
- res_tag_out  output  TAG_W: tag of the originating request.
- res_src_out  output  1: originating requester (0 or 1).

## Operation
- Stages:
  - S1 is the issue register: valid, op1, op2, opcode, tag, src.
  - S2 is the output register: valid, data, tag, src.
- Pipeline control:
  - s2_free = !s2_valid | res_ready_in.
  - s1_free = !s1_valid | s2_free.
  - S1 advances to S2 when s1_valid & s2_free. S2 captures alu_result_in with S1's tag and src.
- Arbitration is round-robin with a 1-bit last_grant register:
  - Only one requester valid: that requester is selected.
  - Both valid: the requester != last_grant is selected.
  - last_grant updates only on an actual transfer, not on a stall.
- Ready rules:
  - reqN_ready_out = selectedN & s1_free & !flush_in.
  - At most one ready is high per cycle.
  - Ready may depend combinationally on res_ready_in.
- A request held valid while stalled must remain stable. The arbiter does not re-arbitrate away from a stalled requester that is already selected unless a higher-turn requester appears; the selection is purely combinational on the current valids.
- Flush:
  - Clears s1_valid and s2_valid at the edge.
  - Blocks acceptance in the flush cycle.
  - Flush takes precedence over a simultaneous accept, advance or pop.
  - last_grant is unchanged.
- Opcode is never decoded; unknown codes pass through to the ALU.
- Datapath registers (operands/data/tag/src) load only when their stage loads. Valid bits alone govern visibility.

## Timing
- Reset (rst_n_in low, asynchronous):
  - s1_valid = s2_valid = 0; all data registers = 0; last_grant = 1, so requester 0 wins first.
  - res_valid_out = 0, res_data_out = 0, res_tag_out = 0, res_src_out = 0.
  - alu_* outputs = 0; both ready outputs = 0.
- Latency:
  - A request accepted at edge k appears on res_valid_out after edge k+1.
  - This is 2 cycles with no backpressure.
- Throughput: one result per cycle while res_ready_in stays high.
- Full: with S1 and S2 valid and res_ready_in low, both ready outputs are 0 and all state holds.
- Pop and accept in the same cycle: S2 loads from S1 and S1 loads the new request. No bubble.
- Reset asserted mid-transfer drops all in-flight results. No result is emitted after deassertion without a new request.

## Configuration
- MSRV32_ALU_ARB_STATS_EN defined:
  - Adds outputs stat_grant0_out, stat_grant1_out, stat_stall_out, each 16 bits.
  - The two grant counters increment per accepted request for requester 0 and requester 1.
  - stat_stall_out increments each cycle with res_valid_out & !res_ready_in.
  - All counters saturate at 16'hFFFF, reset to 0, and are unaffected by flush_in.
- MSRV32_ALU_ARB_STATS_EN undefined: the counters and these ports do not exist. Behaviour is otherwise identical.

## Test plan
- Requester 0 only: op1=10, op2=20, opcode=4'b0000, tag=5 -> res_data_out=30, res_tag_out=5, res_src_out=0, exactly 2 cycles after accept.
- Both valid every cycle, res_ready_in=1:
  - Stimulus: requester 0 sub 30-15 (4'b1000); requester 1 AND 32'hFF & 32'h0F (4'b0111).
  - Response: grants alternate 0,1,0,1, with requester 0 first after reset; results 15, 32'h0F alternating with matching src.
- Backpressure: res_ready_in=0 for 4 cycles with continuous requests -> at most 2 accepted, both readies 0, res_data_out stable. Releasing res_ready_in drains the results in order with no loss.
- Flush with S1 and S2 valid and requester 1 valid in the same cycle -> no accept; res_valid_out=0 the next cycle; the next accepted request is requester 1.
- Asynchronous reset pulse mid-stream -> all outputs 0 immediately; after release, requester 0 has priority.
- With MSRV32_ALU_ARB_STATS_EN: 3 grants to requester 0, 2 to requester 1, and 4 stall cycles -> stat_grant0_out=3, stat_grant1_out=2, stat_stall_out=4.
